// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: parametrised matrix-keypad scanner.
//
// Drives one row low at a time, debounces the active-low column inputs over DEBOUNCE scan
// ticks and reports debounced key changes as codes (row*COLS+col) through a small
// first-word-fall-through event FIFO. The whole block runs in the clk domain; the scan rate
// comes from a tick enable, and no clocks are derived.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   col_in       raw column inputs, active-low, asynchronous to clk
//   row_out      row drive, exactly one bit low
//   ev_valid     FIFO head valid
//   ev_ready     consumer accepts the FIFO head
//   ev_code      key code of the FIFO head, row*COLS+col
//   ev_release   FIFO head is a release event (0 = press)
//   ev_overflow  sticky flag, set when an event was dropped on a full FIFO
//   ovf_clr      clears ev_overflow (a simultaneous drop wins)
//   key_state    debounced key state, bit row*COLS+col, 1 = pressed
//   scan_done    one-clk pulse at the end of each full matrix pass
module keypad_scan_ctrl #(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned CLK_DIV        = 125000,
  parameter int unsigned DEBOUNCE       = 2,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned REPORT_RELEASE = 0,
  localparam int unsigned CODE_W        = ($clog2(ROWS * COLS) > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [COLS-1:0]        col_in,
  output logic [ROWS-1:0]        row_out,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [CODE_W-1:0]      ev_code,
  output logic                   ev_release,
  output logic                   ev_overflow,
  input  logic                   ovf_clr,
  output logic [ROWS*COLS-1:0]   key_state,
  output logic                   scan_done
);

  localparam int unsigned KEYS    = ROWS * COLS;
  localparam int unsigned CNT_W   = $clog2(CLK_DIV);
  localparam int unsigned DWELL_W = $clog2(DEBOUNCE + 2);
  localparam int unsigned ROW_W   = $clog2(ROWS);
  localparam int unsigned COL_W   = $clog2(COLS);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {StDwell, StEmit} state_e;

  // ---------------------------------------------------------------------------------------
  // Column synchroniser
  // ---------------------------------------------------------------------------------------
  logic [COLS-1:0] col_meta_q, col_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_q <= '1;
      col_sync_q <= '1;
    end else begin
      col_meta_q <= col_in;
      col_sync_q <= col_meta_q;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Scan tick: free-running divider, independent of the FSM state
  // ---------------------------------------------------------------------------------------
  logic [CNT_W-1:0] tick_cnt_q;
  logic             tick;

  assign tick = (tick_cnt_q == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------------------
  // Scan state
  // ---------------------------------------------------------------------------------------
  state_e             state_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [ROW_W-1:0]   row_idx_q;
  logic [COL_W-1:0]   col_idx_q;
  logic [ROWS-1:0]    row_out_q;
  logic [KEYS-1:0]    key_state_q;
  // Per column: every sample so far was low / every sample so far was high.
  logic [COLS-1:0]    all_low_q, all_high_q;
  logic               scan_done_q;

  // Per-column decision while emitting; the FIFO push happens in the same clk.
  logic [CODE_W-1:0]  cur_code;
  logic               key_cur;
  logic               cand;
  logic               key_chg;
  logic               push;
  logic               push_rel;

  always_comb begin
    cur_code = CODE_W'(32'(row_idx_q) * COLS + 32'(col_idx_q));
    key_cur  = key_state_q[cur_code];
    // Mixed samples keep the previous debounced state.
    if (all_low_q[col_idx_q]) begin
      cand = 1'b1;
    end else if (all_high_q[col_idx_q]) begin
      cand = 1'b0;
    end else begin
      cand = key_cur;
    end
    key_chg  = (state_q == StEmit) && (cand != key_cur);
    push     = key_chg && (cand || (REPORT_RELEASE != 0));
    push_rel = ~cand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StDwell;
      dwell_q     <= '0;
      row_idx_q   <= '0;
      col_idx_q   <= '0;
      row_out_q   <= ~ROWS'(1);
      key_state_q <= '0;
      all_low_q   <= '0;
      all_high_q  <= '0;
      scan_done_q <= 1'b0;
    end else begin
      scan_done_q <= 1'b0;
      unique case (state_q)
        StDwell: begin
          if (tick) begin
            dwell_q <= dwell_q + DWELL_W'(1);
            // dwell_q == 0 is the settle tick; its column values are ignored.
            if (dwell_q == DWELL_W'(1)) begin
              all_low_q  <= ~col_sync_q;
              all_high_q <= col_sync_q;
            end else if (dwell_q != '0) begin
              all_low_q  <= all_low_q & ~col_sync_q;
              all_high_q <= all_high_q & col_sync_q;
            end
            if (dwell_q == DWELL_W'(DEBOUNCE)) begin
              state_q   <= StEmit;
              col_idx_q <= '0;
            end
          end
        end
        StEmit: begin
          // key_state is updated even when the event itself is dropped on a full FIFO.
          if (key_chg) begin
            key_state_q[cur_code] <= cand;
          end
          if (col_idx_q == COL_W'(COLS - 1)) begin
            state_q   <= StDwell;
            dwell_q   <= '0;
            row_out_q <= {row_out_q[ROWS-2:0], row_out_q[ROWS-1]};
            if (row_idx_q == ROW_W'(ROWS - 1)) begin
              row_idx_q   <= '0;
              scan_done_q <= 1'b1;
            end else begin
              row_idx_q <= row_idx_q + ROW_W'(1);
            end
          end else begin
            col_idx_q <= col_idx_q + COL_W'(1);
          end
        end
        default: state_q <= StDwell;
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------
  // Event FIFO: first-word-fall-through, pointers carry one extra wrap bit
  // ---------------------------------------------------------------------------------------
  logic [CODE_W:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic             fifo_empty, fifo_full;
  logic             pop, wr_en, drop;
  logic             ovf_q;

  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    pop        = !fifo_empty && ev_ready;
    // A pop in the same clk frees the slot the push needs.
    wr_en      = push && (!fifo_full || pop);
    drop       = push && fifo_full && !pop;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {push_rel, cur_code};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------
  assign row_out     = row_out_q;
  assign key_state   = key_state_q;
  assign scan_done   = scan_done_q;
  assign ev_valid    = !fifo_empty;
  assign ev_code     = fifo_mem[rd_ptr_q[PTR_W-1:0]][CODE_W-1:0];
  assign ev_release  = fifo_mem[rd_ptr_q[PTR_W-1:0]][CODE_W];
  assign ev_overflow = ovf_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl. Two instances run in lockstep, one without and one with
// release reporting, each scanning its own copy of a simulated 4x4 keypad. Expected events
// come from a key-matrix model: a matrix applied at a scan boundary is fully debounced after
// one pass, and every changed key reports in ascending code order.
module tb_keypad_scan_ctrl;

  localparam int unsigned FIFO_DEPTH = 4;

  typedef struct packed {
    logic       rel;
    logic [3:0] code;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ev_ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [15:0] phys = '0;
  logic        glitch = 1'b0;
  int          ready_mode = 1;

  logic [3:0]  col_in0, col_in1, row_out0, row_out1, ev_code0, ev_code1;
  logic        ev_valid0, ev_valid1, ev_release0, ev_release1;
  logic        ev_overflow0, ev_overflow1, scan_done0, scan_done1;
  logic [15:0] key_state0, key_state1;

  int          n_checks = 0;
  int          n_fail = 0;
  ev_t         q0[$];
  ev_t         q1[$];
  ev_t         mexp0, mexp1;
  logic [15:0] model = '0;
  logic        exp_ovf0 = 1'b0;
  logic        exp_ovf1 = 1'b0;
  logic [3:0]  exp_rows [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

  always #5 clk = ~clk;

  function automatic logic [3:0] keypad_cols(input logic [15:0] pressed, input logic [3:0] rows,
                                             input logic gl);
    logic [3:0] cols;
    cols = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!rows[r] && pressed[r*4+c]) cols[c] = 1'b0;
      end
    end
    if (gl && !rows[2]) cols[1] = 1'b0;
    return cols;
  endfunction

  assign col_in0 = keypad_cols(phys, row_out0, glitch);
  assign col_in1 = keypad_cols(phys, row_out1, glitch);

  keypad_scan_ctrl #(
    .ROWS(4), .COLS(4), .CLK_DIV(4), .DEBOUNCE(2), .FIFO_DEPTH(4), .REPORT_RELEASE(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .col_in(col_in0), .row_out(row_out0), .ev_valid(ev_valid0),
    .ev_ready(ev_ready), .ev_code(ev_code0), .ev_release(ev_release0),
    .ev_overflow(ev_overflow0), .ovf_clr(ovf_clr), .key_state(key_state0),
    .scan_done(scan_done0)
  );

  keypad_scan_ctrl #(
    .ROWS(4), .COLS(4), .CLK_DIV(4), .DEBOUNCE(2), .FIFO_DEPTH(4), .REPORT_RELEASE(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .col_in(col_in1), .row_out(row_out1), .ev_valid(ev_valid1),
    .ev_ready(ev_ready), .ev_code(ev_code1), .ev_release(ev_release1),
    .ev_overflow(ev_overflow1), .ovf_clr(ovf_clr), .key_state(key_state1),
    .scan_done(scan_done1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Consumer handshake driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       ev_ready = 1'b0;
        1:       ev_ready = 1'b1;
        default: ev_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard monitor: every accepted FIFO head must match the next expected event.
  always @(negedge clk) begin
    if (rst_n && ev_valid0 && ev_ready) begin
      if (q0.size() == 0) begin
        check("rr0_unexpected_event", {27'd0, ev_release0, ev_code0}, 32'hFFFF_FFFF);
      end else begin
        mexp0 = q0.pop_front();
        check("rr0_event", {27'd0, ev_release0, ev_code0}, {27'd0, mexp0});
      end
    end
    if (rst_n && ev_valid1 && ev_ready) begin
      if (q1.size() == 0) begin
        check("rr1_unexpected_event", {27'd0, ev_release1, ev_code1}, 32'hFFFF_FFFF);
      end else begin
        mexp1 = q1.pop_front();
        check("rr1_event", {27'd0, ev_release1, ev_code1}, {27'd0, mexp1});
      end
    end
  end

  // Returns on the negedge that shows the scan_done pulse.
  task automatic wait_scan();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = scan_done0;
    end
    check("scan_done_seen", 32'(seen), 32'd1);
  endtask

  // Applies a new key matrix and queues the events one full pass must produce.
  task automatic apply(input logic [15:0] nxt);
    ev_t e;
    for (int k = 0; k < 16; k++) begin
      if (nxt[k] != model[k]) begin
        e.code = 4'(k);
        e.rel  = ~nxt[k];
        if (nxt[k]) begin
          if (ready_mode == 0 && q0.size() >= FIFO_DEPTH) exp_ovf0 = 1'b1;
          else q0.push_back(e);
        end
        if (ready_mode == 0 && q1.size() >= FIFO_DEPTH) exp_ovf1 = 1'b1;
        else q1.push_back(e);
      end
    end
    model = nxt;
    phys  = nxt;
  endtask

  task automatic check_state(input string name);
    check({name, "_key_state0"}, 32'(key_state0), 32'(model));
    check({name, "_key_state1"}, 32'(key_state1), 32'(model));
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && (q0.size() + q1.size()) != 0; i++) @(negedge clk);
    check({name, "_drained"}, 32'(q0.size() + q1.size()), 32'd0);
  endtask

  initial begin
    logic [3:0]  prev;
    logic [15:0] nxt;
    int          hold, nchg, last_sd, n;
    int unsigned b;
    logic        any_valid;
    bit          seen;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_row_out0", 32'(row_out0), 32'hE);
    check("rst_row_out1", 32'(row_out1), 32'hE);
    check("rst_ev_valid", 32'({ev_valid0, ev_valid1}), 32'd0);
    check("rst_overflow", 32'({ev_overflow0, ev_overflow1}), 32'd0);
    check("rst_key_state", 32'(key_state0 | key_state1), 32'd0);
    check("rst_scan_done", 32'({scan_done0, scan_done1}), 32'd0);
    rst_n = 1'b1;

    // Idle scanning: row rotation, 16-clk row period, 64-clk scan period
    prev = row_out0; hold = 0; nchg = 0; last_sd = -1; any_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      hold++;
      any_valid = any_valid | ev_valid0 | ev_valid1;
      if (row_out0 != prev) begin
        check("idle_row_seq", 32'(row_out0), 32'(exp_rows[nchg % 4]));
        check("idle_row_hold", 32'(hold), 32'd16);
        prev = row_out0; hold = 0; nchg++;
      end
      if (scan_done0) begin
        check("idle_sd_at_row0", 32'(row_out0), 32'hE);
        if (last_sd >= 0) check("idle_sd_period", 32'(i - last_sd), 32'd64);
        last_sd = i;
      end
    end
    check("idle_row_changes", 32'(nchg), 32'd12);
    check("idle_no_valid", 32'(any_valid), 32'd0);

    // Single key (row 2, col 1): press then release
    wait_scan();
    apply(16'h0200);
    wait_scan(); check_state("press9");
    wait_scan(); check_state("hold9");
    check("press9_events_done", 32'(q0.size() + q1.size()), 32'd0);
    apply(16'h0000);
    wait_scan(); check_state("release9");
    wait_scan();
    check("release9_events_done", 32'(q0.size() + q1.size()), 32'd0);

    // Bounce: col1 low across only one sample tick of the row-2 dwell
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = (row_out0 == 4'b1011);
    end
    check("bounce_row2_seen", 32'(seen), 32'd1);
    repeat (4) @(posedge clk);
    #1 glitch = 1'b1;
    repeat (5) @(posedge clk);
    #1 glitch = 1'b0;
    wait_scan();
    wait_scan(); check_state("bounce");

    // FIFO full and overflow with the consumer stalled
    ready_mode = 0;
    wait_scan();
    apply(16'h001F);
    wait_scan(); check_state("ovf");
    check("ovf_valid", 32'({ev_valid0, ev_valid1}), 32'h3);
    check("ovf_flag0", 32'(ev_overflow0), 32'(exp_ovf0));
    check("ovf_flag1", 32'(ev_overflow1), 32'(exp_ovf1));
    ready_mode = 1;
    wait_drain("ovf");
    check("ovf_sticky", 32'({ev_overflow0, ev_overflow1}), 32'h3);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    exp_ovf0 = 1'b0; exp_ovf1 = 1'b0;
    check("ovf_cleared", 32'({ev_overflow0, ev_overflow1}), 32'd0);
    wait_scan();
    apply(16'h0000);
    wait_scan(); check_state("ovf_release");
    wait_drain("ovf_release");

    // Reset while emitting row 0 with two events queued
    ready_mode = 0;
    wait_scan();
    apply(16'h0003);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = ev_valid0;
    end
    check("midrst_first_event", 32'(seen), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ev_valid", 32'({ev_valid0, ev_valid1}), 32'd0);
    check("midrst_key_state", 32'(key_state0 | key_state1), 32'd0);
    check("midrst_row_out", 32'({row_out1, row_out0}), 32'hEE);
    q0.delete(); q1.delete();
    model = '0; phys = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold = 0;
    for (int i = 0; i < 40 && row_out0 == 4'b1110; i++) begin
      @(negedge clk);
      hold++;
    end
    check("midrst_row0_hold", 32'(hold), 32'd16);
    check("midrst_next_row", 32'(row_out0), 32'hD);

    // Randomised key matrices with a randomly stalling consumer
    ready_mode = 2;
    for (int it = 0; it < 25; it++) begin
      wait_scan();
      check_state("rand");
      if (q0.size() == 0 && q1.size() == 0) begin
        nxt = model;
        n = int'($urandom_range(1, 4));
        for (int j = 0; j < n; j++) begin
          b = $urandom_range(0, 15);
          nxt[b[3:0]] = ~nxt[b[3:0]];
        end
        apply(nxt);
      end
    end
    ready_mode = 1;
    wait_scan();
    check_state("final");
    wait_drain("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected the test to finish");
    $fatal(1, "watchdog");
  end

endmodule
